// File: rtl/alu_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU op codes, state encoding, defaults.
// The DIV state exists only when ALU_MULT_SEQ_DIV_EN is defined.
package alu_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  // Bit 3 = ainvert, bit 2 = binvert (and carry-in), bits 1:0 = and/or/add/slt
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

`ifdef ALU_MULT_SEQ_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd3
  } seq_state_t;
`endif

endpackage

// File: rtl/alu_seq_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step for the {hi, lo} pair.
// The shared ALU only returns a 16-bit sum, so the carry/borrow is rebuilt here from the MSBs.
module alu_seq_step
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] rem_shift_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic carry;
  logic noBorrow;
  logic divOk;

  assign rem_shift_o = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};

  // hi[15] set before the shift means the true partial remainder is 17 bits and always >= divisor
  always_comb begin
    carry    = (hi_i[WIDTH-1] & operand_i[WIDTH-1]) |
               ((hi_i[WIDTH-1] | operand_i[WIDTH-1]) & ~alu_result_i[WIDTH-1]);
    noBorrow = (rem_shift_o[WIDTH-1] & ~operand_i[WIDTH-1]) |
               ((rem_shift_o[WIDTH-1] | ~operand_i[WIDTH-1]) & ~alu_result_i[WIDTH-1]);
    divOk    = hi_i[WIDTH-1] | noBorrow;
    hi_o     = hi_i;
    lo_o     = lo_i;
    if (div_mode_i) begin
      hi_o = divOk ? alu_result_i : rem_shift_o;
      lo_o = {lo_i[WIDTH-2:0], divOk};
    end else if (lo_i[0]) begin
      hi_o = {carry, alu_result_i[WIDTH-1:1]};
      lo_o = {alu_result_i[0], lo_i[WIDTH-1:1]};
    end else begin
      hi_o = {1'b0, hi_i[WIDTH-1:1]};
      lo_o = {hi_i[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle multiply/divide sequencer that time-shares the 16-bit ALU, one iteration per clock.
// Optional divide support is compiled in with the macro ALU_MULT_SEQ_DIV_EN.
module alu_mult_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  seq_state_t       state_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] remShift;
  logic [WIDTH-1:0] stepOperand;
  logic             stepDiv;

`ifdef ALU_MULT_SEQ_DIV_EN
  logic [WIDTH-1:0] dvsr_q;

  assign stepDiv     = (state_q == S_DIV);
  assign stepOperand = stepDiv ? dvsr_q : mcand_q;
`else
  logic unusedOpDiv;

  assign unusedOpDiv = op_div;
  assign stepDiv     = 1'b0;
  assign stepOperand = mcand_q;
`endif

  alu_seq_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i  (stepDiv),
    .hi_i        (hi_q),
    .lo_i        (lo_q),
    .operand_i   (stepOperand),
    .alu_result_i(alu_result),
    .rem_shift_o (remShift),
    .hi_o        (hi_d),
    .lo_o        (lo_d)
  );

  // The ALU is parked on AND with zero operands whenever no iteration is running
  always_comb begin
    alu_op = ALU_AND;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      S_MUL: begin
        alu_op = ALU_ADD;
        alu_a  = hi_q;
        alu_b  = mcand_q;
      end
`ifdef ALU_MULT_SEQ_DIV_EN
      S_DIV: begin
        alu_op = ALU_SUB;
        alu_a  = remShift;
        alu_b  = dvsr_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MULT_SEQ_DIV_EN
      dvsr_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            busy_q <= 1'b1;
`ifdef ALU_MULT_SEQ_DIV_EN
            if (op_div) begin
              // Divide by zero short-circuits straight to DONE with an all-ones quotient
              if (src_b == '0) begin
                hi_q    <= src_a;
                lo_q    <= '1;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                lo_q    <= src_a;
                dvsr_q  <= src_b;
                state_q <= S_DIV;
              end
            end else begin
              lo_q    <= src_b;
              mcand_q <= src_a;
              state_q <= S_MUL;
            end
`else
            lo_q    <= src_b;
            mcand_q <= src_a;
            state_q <= S_MUL;
`endif
          end
        end
`ifdef ALU_MULT_SEQ_DIV_EN
        S_MUL, S_DIV: begin
`else
        S_MUL: begin
`endif
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
